// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit path.
//   t_state        : frame/word sequencing states.
//   DEF_*          : default widths used by the transmitter modules.
//   BITS_PER_FRAME : start + data bits + stop (8N1).
//   BYTES_PER_WORD : bytes carried per result word.
//   cnt_width()    : counter width for a modulus, never below 1 bit.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT
  } t_state;

  localparam int DEF_SIZE_DATA     = 32;
  localparam int DEF_SIZE_BYTE     = 8;
  localparam int DEF_OVER_SAMPLING = 16;

  localparam int BITS_PER_FRAME = DEF_SIZE_BYTE + 2;
  localparam int BYTES_PER_WORD = DEF_SIZE_DATA / DEF_SIZE_BYTE;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as an 8N1 frame: start bit, data bits LSB first, stop bit.
// Each bit lasts OVER_SAMPLING baud sticks.
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_stick      baud tick (oversampled)
//   i_start      begin a frame with i_byte (honoured only while idle)
//   i_chain      this start directly follows a previous frame of the same word
//   i_byte       byte to send
//   o_tx         serial line, idle high
//   o_byte_done  high in the cycle whose edge ends the stop bit
// -----------------------------------------------------------------------------
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int SIZE_BYTE     = DEF_SIZE_BYTE,
  parameter int OVER_SAMPLING = DEF_OVER_SAMPLING
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_start,
  input  logic                 i_chain,
  input  logic [SIZE_BYTE-1:0] i_byte,
  output logic                 o_tx,
  output logic                 o_byte_done
);

  localparam int CNT_W = cnt_width(OVER_SAMPLING);
  localparam int BIT_W = cnt_width(SIZE_BYTE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_SAMPLING - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SIZE_BYTE - 1);

  t_state               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [BIT_W-1:0]     r_bit, w_bit_next;
  logic [SIZE_BYTE-1:0] r_shift, w_shift_next;
  logic                 w_tick_last;

  // The stick that completes the current bit period.
  assign w_tick_last = i_stick & (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;

    if (r_state != IDLE && i_stick) begin
      w_cnt_next = w_tick_last ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = START;
          w_shift_next = i_byte;
          w_bit_next   = '0;
          // A word's first frame ignores a stick on its accept edge; later
          // frames keep the word's bit clock running through the gap cycle.
          w_cnt_next   = (i_chain && i_stick) ? CNT_W'(1) : '0;
        end
      end
      START: begin
        if (w_tick_last) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick_last) begin
          if (r_bit == BIT_LAST) begin
            w_state_next = STOP;
          end else begin
            w_bit_next   = r_bit + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
      STOP: begin
        if (w_tick_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  // Line level decoded from registered state only.
  always_comb begin
    case (r_state)
      START:   o_tx = 1'b0;
      DATA:    o_tx = r_shift[0];
      default: o_tx = 1'b1;
    endcase
  end

  assign o_byte_done = (r_state == STOP) & w_tick_last;

endmodule

// File: rtl/uart_tx_result_sender.sv
// -----------------------------------------------------------------------------
// uart_tx_result_sender
// Accepts one result word per valid/ready handshake and sends it as a series
// of 8N1 UART frames, one per byte, then pulses o_done.
// Ports:
//   i_clk    system clock
//   i_rst    synchronous reset, active-high
//   i_stick  baud tick at OVER_SAMPLING x baud rate
//   i_tx_en  transmitter enable (gates new words only)
//   i_valid  result word available
//   i_data   result word
//   o_ready  word accepted this cycle if i_valid
//   o_busy   a word is being transmitted
//   o_tx     serial line, idle high
//   o_done   one-cycle pulse after the final stop bit of a word
// -----------------------------------------------------------------------------
module uart_tx_result_sender
  import uart_pkg::*;
#(
  parameter int SIZE_DATA      = DEF_SIZE_DATA,
  parameter int SIZE_BYTE      = DEF_SIZE_BYTE,
  parameter int OVER_SAMPLING  = DEF_OVER_SAMPLING,
  parameter int MSB_BYTE_FIRST = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_tx_en,
  input  logic                 i_valid,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_tx,
  output logic                 o_done
);

  localparam int N_BYTES = SIZE_DATA / SIZE_BYTE;
  localparam int BCNT_W  = cnt_width(N_BYTES);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(N_BYTES - 1);

  // Word-level states used here: IDLE, DATA (a frame is on the line),
  // NEXT (single gap cycle that selects the following byte).
  t_state               r_state, w_state_next;
  logic [SIZE_DATA-1:0] r_word, w_word_next;
  logic [BCNT_W-1:0]    r_byte_cnt, w_byte_cnt_next;
  logic                 r_done, w_done_next;

  logic                 w_accept;
  logic                 w_start;
  logic                 w_chain;
  logic                 w_byte_done;
  logic [SIZE_DATA-1:0] w_word_src;
  logic [SIZE_BYTE-1:0] w_lane [N_BYTES];
  logic [BCNT_W-1:0]    w_lane_idx;

  assign o_ready  = (r_state == IDLE) & i_tx_en & ~i_rst;
  assign w_accept = i_valid & o_ready;

  // The first byte leaves on the accept edge, before the word is latched.
  assign w_word_src = (r_state == IDLE) ? i_data : r_word;

  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lane
      assign w_lane[gi] = w_word_src[gi*SIZE_BYTE +: SIZE_BYTE];
    end
  endgenerate

  assign w_lane_idx = (MSB_BYTE_FIRST != 0) ? (BCNT_LAST - r_byte_cnt) : r_byte_cnt;
  assign w_chain    = (r_state == NEXT);
  assign w_start    = w_accept | w_chain;

  always_comb begin
    w_state_next    = r_state;
    w_word_next     = r_word;
    w_byte_cnt_next = r_byte_cnt;
    w_done_next     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next    = DATA;
          w_word_next     = i_data;
          w_byte_cnt_next = '0;
        end
      end
      DATA: begin
        if (w_byte_done) begin
          if (r_byte_cnt == BCNT_LAST) begin
            w_state_next    = IDLE;
            w_byte_cnt_next = '0;
            w_done_next     = 1'b1;
          end else begin
            w_state_next    = NEXT;
            w_byte_cnt_next = r_byte_cnt + 1'b1;
          end
        end
      end
      NEXT:    w_state_next = DATA;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_word     <= w_word_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_done     <= w_done_next;
    end
  end

  uart_tx_byte #(
    .SIZE_BYTE     (SIZE_BYTE),
    .OVER_SAMPLING (OVER_SAMPLING)
  ) u_tx_byte (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stick     (i_stick),
    .i_start     (w_start),
    .i_chain     (w_chain),
    .i_byte      (w_lane[w_lane_idx]),
    .o_tx        (o_tx),
    .o_byte_done (w_byte_done)
  );

  assign o_busy = (r_state != IDLE);
  assign o_done = r_done;

endmodule

// File: doc/uart_tx_result_sender.md
Name: uart_tx_result_sender

Overview:
- Downstream stage of the UART receive path and the floating-point core.
- Takes one 32-bit result word per handshake, splits it into 4 bytes, and serialises each byte as an 8N1 UART frame on o_tx.
- Bit timing comes from the shared baud stick at 16x oversampling, the same tick that drives the receive side.
- Raises o_done for one cycle when the last stop bit of the word completes.

Parameters:
- SIZE_DATA, 32, width of the result word; must be a multiple of 8.
- SIZE_BYTE, 8, data bits per UART frame.
- OVER_SAMPLING, 16, sticks per UART bit.
- MSB_BYTE_FIRST, 1, 1 = byte [31:24] sent first; 0 = byte [7:0] sent first.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_stick  in  1  baud tick, one-cycle pulse at 16x the baud rate.
- i_tx_en  in  1  transmitter enable.
- i_valid  in  1  result word available.
- i_data  in  SIZE_DATA  result word.
- o_ready  out  1  word accepted this cycle if i_valid=1.
- o_busy  out  1  a word is being transmitted.
- o_tx  out  1  serial line, idle high.
- o_done  out  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (i_rst=1 at an edge): o_tx=1, o_busy=0, o_done=0; state IDLE; counters and shift register cleared. This includes reset mid-frame, where o_tx returns high at that same edge.
- o_ready = (state==IDLE) & i_tx_en & ~i_rst. It is combinational from state and i_tx_en.
- Accept: i_valid & o_ready at edge N.
  - i_data is latched.
  - o_busy goes to 1 at N.
  - State goes to START and o_tx=0 from edge N. No stick is required to start.
- States:
  - IDLE: o_tx=1.
  - START: o_tx=0.
  - DATA: o_tx = current data bit, LSB of the byte first.
  - STOP: o_tx=1.
  - NEXT: one clock, selects the next byte, no stick needed.
- Bit duration: a stick counter (0..OVER_SAMPLING-1) increments on each i_stick. The state or bit advances on the stick that brings the count to OVER_SAMPLING-1, after which the counter wraps to 0.
  - A stick coincident with the accept edge is not counted.
- Transitions:
  - START → DATA after 16 sticks.
  - DATA → DATA for bits 0..6; after bit 7 → STOP.
  - STOP → NEXT after 16 sticks, if bytes sent < SIZE_DATA/8.
  - STOP → IDLE after 16 sticks, on the last byte.
  - NEXT → START on the following edge.
- Completion: on the STOP → IDLE edge, o_done=1 for exactly one cycle and o_busy=0.
  - o_ready rises in that same cycle, so back-to-back words are allowed with a one-cycle idle gap minimum.
- i_valid while busy: ignored, since o_ready=0. i_data changes after acceptance have no effect.
- i_tx_en deasserted mid-word: the current word completes. No new accept happens until i_tx_en=1.
- Byte counter: 2 bits, wraps 3 → 0 only on return to IDLE.
- Byte index: with MSB_BYTE_FIRST=1, bytes go out in the order 3, 2, 1, 0.
- Sticks per word = 4 × 10 × 16 = 640.

Decomposition:
- Shared package uart_pkg:
  - state enum: IDLE, START, DATA, STOP, NEXT.
  - localparams: BITS_PER_FRAME=10, BYTES_PER_WORD=SIZE_DATA/SIZE_BYTE.
  - stick-counter width function $clog2(OVER_SAMPLING).
- One natural sub-module, uart_tx_byte:
  - Serialises one byte: start bit, 8 data bits, stop bit.
  - Handshake is i_start and o_byte_done.
  - The top level owns word latching, the byte counter and o_done.

Test Plan:
1. Reset and idle: i_rst=1 for 3 cycles, then 0, i_tx_en=1, i_valid=0 → o_tx=1, o_ready=1, o_busy=0, o_done=0 held for 100 cycles.
2. Single word, i_stick tied 1: i_data=32'h3F800000, MSB_BYTE_FIRST=1.
   - Byte sequence on o_tx is 3F, 80, 00, 00.
   - First frame: 0, 1,1,1,1,1,1,0,0, 1, each level held 16 cycles.
   - o_done pulses exactly 640 cycles after the accept edge; o_busy is high for those 640 cycles.
3. Sparse stick: i_stick every 4th cycle, i_data=32'hA5A5_0001 → each bit lasts 64 cycles; the decoded bytes A5, A5, 00, 01 match a bench UART monitor.
4. Busy handshake: i_valid held 1 with i_data=32'h1 and then 32'h2 → second word accepted only in the o_done cycle. o_ready=0 throughout the first transmission, and exactly two words are sent.
5. Reset mid-frame: i_rst=1 during the DATA bit 3 of byte 2 → o_tx=1 and o_busy=0 at that edge, with no o_done. A subsequent word 32'hC0000000 transmits correctly from its start bit.
6. Enable gating: i_tx_en=0 with i_valid=1 → o_ready=0 and no start bit. Dropping i_tx_en mid-word lets that word finish and produces o_done.
